d8m_pixel_pattern_gen: RTL and testbench
========================================

Name: d8m_pixel_pattern_gen

Overview:
- Synthetic source for the D8M camera pixel interface.
- Drives a raw 10-bit Bayer stream with frame-valid/line-valid framing, the same interface that D8M_SET consumes on MIPI_PIXEL_D/HS/VS.
- Lets the capture and RGB path, edge-detect FIFOs and VGA output be exercised on the board or in simulation without the D8M module.
- Sits on the MIPI_PIXEL_CLK domain; a top-level mux selects it in place of the camera pins.

Parameters:
- H_ACTIVE, 640, pixels per line (LVAL high cycles).
- H_BLANK, 160, LVAL-low cycles between lines within a frame.
- V_ACTIVE, 480, lines per frame.
- FV_LEAD, 16, cycles FVAL high before first LVAL of a frame.
- FV_TAIL, 16, cycles FVAL high after last line's HBLANK.
- V_BLANK, 8000, FVAL-low cycles between frames.
- BAR_SHIFT, 6, log2 of colour-bar width in pixels.

Ports:
- MIPI_PIXEL_CLK  in  1  pixel clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  1  run request.
- MODE  in  2  pattern: 00 bars, 01 ramp, 10 checker, 11 solid.
- SOLID  in  10  grey level for MODE=11.
- PIXEL_D  out  10  Bayer sample.
- PIXEL_HS  out  1  line valid (LVAL).
- PIXEL_VS  out  1  frame valid (FVAL).
- FRAME_DONE  out  1  one-cycle pulse, last FRAME_TAIL cycle.
- FRAME_CNT  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset: all outputs 0, FSM to IDLE. The same holds when reset is asserted mid-frame; no partial-line completion.
- All outputs are registered. PIXEL_D is 0 whenever PIXEL_HS is 0.
- FSM states: IDLE, LEAD, ACTIVE, HBLANK, TAIL, VBLANK.
- IDLE: FVAL=0, LVAL=0. When EN=1 is sampled, go to LEAD; FVAL=1 on the next edge. MODE and SOLID are latched here.
- LEAD: FVAL=1 for FV_LEAD cycles, then ACTIVE.
- ACTIVE: LVAL=1 for exactly H_ACTIVE cycles; col counts 0..H_ACTIVE-1. Then HBLANK.
- HBLANK: LVAL=0 for H_BLANK cycles. Then row++ and go to ACTIVE, or to TAIL after row V_ACTIVE-1.
- TAIL: FVAL=1 for FV_TAIL cycles. FRAME_DONE pulses on the last TAIL cycle, and FRAME_CNT increments on that same edge.
- VBLANK: FVAL=0 for V_BLANK cycles. At the end, sample EN: 1 -> LEAD (re-latch MODE/SOLID), 0 -> IDLE.
- EN deasserted mid-frame has no effect until the frame completes; no truncated frames.
- MODE changes mid-frame are ignored until the next latch.
- Pattern values are 10-bit, computed from the current col/row (col, row 10 bits):
  - Bars: bar = col[BAR_SHIFT+2:BAR_SHIFT]; c = 3'b111 - bar; R/G/B = 0x3FF if c[2]/c[1]/c[0] set, else 0.
  - Ramp: R=G=B=col[9:0].
  - Checker: R=G=B = (col[3]^row[3]) ? 0x3FF : 0.
  - Solid: R=G=B=latched SOLID.
- Bayer selection (GRBG):
  - row even, col even -> G.
  - row even, col odd -> R.
  - row odd, col even -> B.
  - row odd, col odd -> G.
- PIXEL_D for col N appears in the same cycle as the Nth LVAL-high cycle (pattern pipeline hidden behind LEAD/HBLANK).
- Counters are sized clog2(param+1); no wrap within a frame.

Optional Feature:
- Macro PATGEN_SCROLL_EN.
- When defined: pattern column index = col + FRAME_CNT (mod 1024) for bars, ramp and checker, so the image scrolls 1 px per frame. Bayer phase still uses the unscrolled col/row.
- When undefined: static pattern, no adder present.

Test Plan:
- Params H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, FV_LEAD=2, FV_TAIL=2, V_BLANK=6; EN=1 after reset -> FVAL rises 1 cycle later; 4 LVAL pulses of 8 cycles, 4 apart. FVAL high 2+4*(8+4)+2=52 cycles; FRAME_DONE single pulse; FRAME_CNT=1.
- MODE=11, SOLID=0x155 -> every LVAL-high sample =0x155; PIXEL_D=0 on all LVAL-low cycles.
- MODE=01, H_ACTIVE=8 -> row 0 samples 0,1,...,7; row 1 identical values. Check Bayer channel is not visible since R=G=B.
- MODE=00, BAR_SHIFT=1 -> row 0: col0 G=0x3FF, col1 R=0x3FF, col2 (bar1, c=110) G=0x3FF, col3 R=0x3FF. Row 1: col4 (bar2, c=101) B=0x3FF, col5 G=0.
- EN dropped mid row 2 -> frame completes, FRAME_CNT increments, then IDLE with FVAL=0 indefinitely. Changing MODE mid-frame -> no change until next frame.
- RESET_N low during ACTIVE -> PIXEL_HS/VS/D, FRAME_CNT=0 immediately (async). After release with EN=1, a clean frame starts with LEAD; FRAME_CNT wraps 255->0 after 256 frames.

Source files
------------

// File: rtl/d8m_pixel_pattern_gen.sv
// ---------------------------------------------------------------------------
// d8m_pixel_pattern_gen
//
// Synthetic raw-Bayer (GRBG, 10-bit) source that mimics the D8M camera pixel
// interface: frame valid (PIXEL_VS) and line valid (PIXEL_HS) framing, with
// the sample on PIXEL_D. Runs entirely on MIPI_PIXEL_CLK, so a top-level mux
// can select it in place of the camera pins.
//
// Ports:
//   MIPI_PIXEL_CLK  in   pixel clock, rising edge
//   RESET_N         in   asynchronous active-low reset
//   EN              in   run request, sampled only between frames
//   MODE[1:0]       in   00 bars, 01 ramp, 10 checker, 11 solid
//   SOLID[9:0]      in   grey level used by MODE=11
//   PIXEL_D[9:0]    out  Bayer sample, 0 whenever PIXEL_HS is low
//   PIXEL_HS        out  line valid
//   PIXEL_VS        out  frame valid
//   FRAME_DONE      out  one-cycle pulse on the last tail cycle of a frame
//   FRAME_CNT[7:0]  out  completed frames, wraps 255 -> 0
//
// Optional build macro PATGEN_SCROLL_EN: pattern column becomes
// col + FRAME_CNT (mod 1024) so bars/ramp/checker scroll 1 px per frame.
// The Bayer phase always uses the unscrolled col/row.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | FVAL=0, waiting for EN; MODE/SOLID latched on exit
// LEAD    | FVAL=1 for FV_LEAD cycles before the first line
// ACTIVE  | LVAL=1, one pixel per cycle, col 0..H_ACTIVE-1
// HBLANK  | LVAL=0 for H_BLANK cycles, then next row or TAIL
// TAIL    | FVAL=1 for FV_TAIL cycles; FRAME_DONE on the last one
// VBLANK  | FVAL=0 for V_BLANK cycles, then EN decides LEAD or IDLE
// ---------------------------------------------------------------------------
module d8m_pixel_pattern_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 480,
    parameter int FV_LEAD   = 16,
    parameter int FV_TAIL   = 16,
    parameter int V_BLANK   = 8000,
    parameter int BAR_SHIFT = 6
) (
    input  logic       MIPI_PIXEL_CLK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic [1:0] MODE,
    input  logic [9:0] SOLID,
    output logic [9:0] PIXEL_D,
    output logic       PIXEL_HS,
    output logic       PIXEL_VS,
    output logic       FRAME_DONE,
    output logic [7:0] FRAME_CNT
);

    localparam int COL_W   = $clog2(H_ACTIVE + 1);
    localparam int ROW_W   = $clog2(V_ACTIVE + 1);
    localparam int MAX_AB  = (FV_LEAD > H_BLANK) ? FV_LEAD : H_BLANK;
    localparam int MAX_CD  = (FV_TAIL > V_BLANK) ? FV_TAIL : V_BLANK;
    localparam int TMR_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] LEAD_LD  = TMR_W'(FV_LEAD - 1);
    localparam logic [TMR_W-1:0] HBLK_LD  = TMR_W'(H_BLANK - 1);
    localparam logic [TMR_W-1:0] TAIL_LD  = TMR_W'(FV_TAIL - 1);
    localparam logic [TMR_W-1:0] VBLK_LD  = TMR_W'(V_BLANK - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEAD   = 3'd1,
        S_ACTIVE = 3'd2,
        S_HBLANK = 3'd3,
        S_TAIL   = 3'd4,
        S_VBLANK = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [1:0]         mode_q, mode_d;
    logic [9:0]         solid_q, solid_d;
    logic [9:0]         pix_q, pix_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               done_q, done_d;
    logic [7:0]         cnt_q, cnt_d;

    // Pattern datapath signals
    logic [9:0] col_x, row_x, col_p;
    logic [2:0] bar, bar_c;
    logic       row_odd, col_odd, chk;
    logic [9:0] r_v, g_v, b_v, bayer_v;

    // -----------------------------------------------------------------------
    // Next-state logic. Outputs are registered from the next state so that
    // PIXEL_* line up exactly with the state they describe.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        col_d   = col_q;
        row_d   = row_q;
        mode_d  = mode_q;
        solid_d = solid_q;

        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_LEAD;
                    tmr_d   = LEAD_LD;
                    mode_d  = MODE;
                    solid_d = SOLID;
                end
            end
            S_LEAD: begin
                if (tmr_q == '0) begin
                    state_d = S_ACTIVE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (col_q == COL_LAST) begin
                    state_d = S_HBLANK;
                    tmr_d   = HBLK_LD;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_HBLANK: begin
                if (tmr_q == '0) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_TAIL;
                        tmr_d   = TAIL_LD;
                    end else begin
                        state_d = S_ACTIVE;
                        row_d   = row_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_TAIL: begin
                if (tmr_q == '0) begin
                    state_d = S_VBLANK;
                    tmr_d   = VBLK_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_VBLANK: begin
                if (tmr_q == '0) begin
                    if (EN) begin
                        state_d = S_LEAD;
                        tmr_d   = LEAD_LD;
                        mode_d  = MODE;
                        solid_d = SOLID;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Pattern generation from the next col/row, so the registered sample is
    // valid in the same cycle LVAL goes high for that column.
    // -----------------------------------------------------------------------
    always_comb begin
        col_x = 10'(col_d);
        row_x = 10'(row_d);
`ifdef PATGEN_SCROLL_EN
        col_p = col_x + {2'b00, cnt_q};
`else
        col_p = col_x;
`endif
        // Whole-vector masks keep every bit of row_x/col_x referenced.
        row_odd = |(row_x & 10'h001);
        col_odd = |(col_x & 10'h001);
        chk     = col_p[3] ^ (|(row_x & 10'h008));
        bar     = col_p[BAR_SHIFT+2:BAR_SHIFT];
        bar_c   = 3'b111 - bar;

        r_v = '0;
        g_v = '0;
        b_v = '0;
        case (mode_d)
            2'b00: begin
                r_v = {10{bar_c[2]}};
                g_v = {10{bar_c[1]}};
                b_v = {10{bar_c[0]}};
            end
            2'b01: begin
                r_v = col_p;
                g_v = col_p;
                b_v = col_p;
            end
            2'b10: begin
                r_v = {10{chk}};
                g_v = {10{chk}};
                b_v = {10{chk}};
            end
            default: begin
                r_v = solid_d;
                g_v = solid_d;
                b_v = solid_d;
            end
        endcase

        // GRBG mosaic
        case ({row_odd, col_odd})
            2'b00:   bayer_v = g_v;
            2'b01:   bayer_v = r_v;
            2'b10:   bayer_v = b_v;
            default: bayer_v = g_v;
        endcase
    end

    always_comb begin
        vs_d   = (state_d == S_LEAD) || (state_d == S_ACTIVE) ||
                 (state_d == S_HBLANK) || (state_d == S_TAIL);
        hs_d   = (state_d == S_ACTIVE);
        done_d = (state_d == S_TAIL) && (tmr_d == '0);
        cnt_d  = cnt_q + {7'd0, done_d};
        pix_d  = hs_d ? bayer_v : 10'd0;
    end

    always_ff @(posedge MIPI_PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            pix_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            pix_q   <= pix_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PIXEL_D    = pix_q;
    assign PIXEL_HS   = hs_q;
    assign PIXEL_VS   = vs_q;
    assign FRAME_DONE = done_q;
    assign FRAME_CNT  = cnt_q;

endmodule

// File: tb/tb_d8m_pixel_pattern_gen.sv
// ---------------------------------------------------------------------------
// Directed bench for d8m_pixel_pattern_gen with a small frame geometry:
// H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, FV_LEAD=2, FV_TAIL=2, V_BLANK=6,
// BAR_SHIFT=1. Frame = 52 FVAL-high cycles followed by 6 FVAL-low cycles.
// ---------------------------------------------------------------------------
module tb_d8m_pixel_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [9:0] solid;
    logic [9:0] pixel_d;
    logic       pixel_hs;
    logic       pixel_vs;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt;

    always #5 clk = ~clk;

    d8m_pixel_pattern_gen #(
        .H_ACTIVE  (8),
        .H_BLANK   (4),
        .V_ACTIVE  (4),
        .FV_LEAD   (2),
        .FV_TAIL   (2),
        .V_BLANK   (6),
        .BAR_SHIFT (1)
    ) dut (
        .MIPI_PIXEL_CLK (clk),
        .RESET_N        (rst_n),
        .EN             (en),
        .MODE           (mode),
        .SOLID          (solid),
        .PIXEL_D        (pixel_d),
        .PIXEL_HS       (pixel_hs),
        .PIXEL_VS       (pixel_vs),
        .FRAME_DONE     (frame_done),
        .FRAME_CNT      (frame_cnt)
    );

    // {VS, HS, DONE, D[9:0], CNT[7:0]}
    function automatic logic [20:0] pack(input logic vs, input logic hs,
                                         input logic dn, input logic [9:0] d,
                                         input logic [7:0] c);
        return {vs, hs, dn, d, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived samples for the 8x4 test geometry.
    // Bars (BAR_SHIFT=1): bit c of the mask is 1 where the sample is 0x3FF.
    //   even rows: 3FF 3FF 3FF 3FF 0 3FF 0 3FF
    //   odd rows : 3FF 3FF 0 3FF 3FF 0 0 0
    function automatic logic [9:0] exp_pix(input logic [1:0] m,
                                           input logic [9:0] s,
                                           input int r, input int c);
        logic [7:0] mask;
        case (m)
            2'b11:   return s;
            2'b01:   return 10'(c);
            2'b10:   return 10'd0;
            default: begin
                mask = ((r % 2) == 0) ? 8'b1010_1111 : 8'b0001_1011;
                return mask[c] ? 10'h3FF : 10'h000;
            end
        endcase
    endfunction

    task automatic wait_vs(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pixel_vs === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_fval_rise"}, {31'd0, found}, 32'd1);
    endtask

    // Starts on the negedge of the first LEAD cycle.
    task automatic walk_frame(input string tag, input logic [1:0] m,
                              input logic [9:0] s, input int drop_en_at);
        logic       ehs, edn;
        logic [9:0] ed;
        int         j, r, p;
        for (int k = 0; k < 52; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_en_at) en = 1'b0;
            ehs = 1'b0;
            edn = 1'b0;
            ed  = 10'd0;
            if (k >= 2 && k < 50) begin
                j = k - 2;
                r = j / 12;
                p = j % 12;
                if (p < 8) begin
                    ehs = 1'b1;
                    ed  = exp_pix(m, s, r, p);
                end
            end
            if (k == 51) begin
                edn     = 1'b1;
                exp_cnt = exp_cnt + 8'd1;
            end
            chk($sformatf("%s_f[%0d]", tag, k),
                {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)},
                {11'd0, pack(1'b1, ehs, edn, ed, exp_cnt)});
        end
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            chk($sformatf("%s_vb[%0d]", tag, v),
                {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)},
                {11'd0, pack(1'b0, 1'b0, 1'b0, 10'd0, exp_cnt)});
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        solid   = 10'd0;
        exp_cnt = 8'd0;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_en0",
            {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)}, 32'd0);

        // Frame 1: solid 0x155; MODE/SOLID changed after latch must be ignored
        mode  = 2'b11;
        solid = 10'h155;
        en    = 1'b1;
        wait_vs("solid");
        mode  = 2'b01;
        solid = 10'h0AA;
        walk_frame("solid", 2'b11, 10'h155, -1);

        // Frame 2: ramp latched at the VBLANK->LEAD boundary
        wait_vs("ramp");
        mode = 2'b00;
        walk_frame("ramp", 2'b01, 10'h0AA, -1);

        // Frame 3: colour bars
        wait_vs("bars");
        mode = 2'b10;
        walk_frame("bars", 2'b00, 10'h0AA, -1);

        // Frame 4: checker, EN dropped in row 2 -> frame still completes
        wait_vs("chkr");
        mode = 2'b11;
        walk_frame("chkr", 2'b10, 10'h0AA, 28);

        for (int i = 0; i < 6; i++) begin
            repeat (5) @(negedge clk);
            chk($sformatf("idle_after_drop[%0d]", i),
                {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)},
                {11'd0, pack(1'b0, 1'b0, 1'b0, 10'd0, 8'd4)});
        end

        // Asynchronous reset in the middle of an active line
        mode  = 2'b11;
        solid = 10'h2AA;
        en    = 1'b1;
        wait_vs("pre_rst");
        repeat (4) @(negedge clk);
        chk("pre_rst_line",
            {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)},
            {11'd0, pack(1'b1, 1'b1, 1'b0, 10'h2AA, 8'd4)});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst",
            {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)}, 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_vs("post_rst");
        walk_frame("post_rst", 2'b11, 10'h2AA, -1);

        // 255 more frames: FRAME_CNT reaches 255 and wraps to 0
        for (int f = 0; f < 255; f++) begin
            wait_vs("wrap");
            walk_frame("wrap", 2'b11, 10'h2AA, -1);
        end
        chk("wrap_final", {24'd0, frame_cnt}, 32'd0);

        en = 1'b0;
        repeat (70) @(negedge clk);
        chk("final_idle",
            {11'd0, pack(pixel_vs, pixel_hs, frame_done, pixel_d, frame_cnt)}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
